// File: rtl/multicycle_ctrl_fsm.sv
// Self-sequencing fetch/execute controller for the multi-cycle CPU.
// Select encodings follow INSTRUCTIONS.v; outputs decode from registered state plus ins_*.
module multicycle_ctrl_fsm #(
    parameter int BUS_TIMEOUT = 16,
    parameter int ALU_LAT     = 1,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             BUS_rdata_valid,
    input  logic             BUS_write_done,
    input  logic             ins_ADD,
    input  logic             ins_SUB,
    input  logic             ins_SW,
    input  logic             ins_LW,
    input  logic             ins_ADDI,
    input  logic             ins_LUI,
    input  logic             ins_JAL,
    input  logic             ins_BEQ,
    input  logic             alu_zero,
    output logic             Mif,
    output logic             Mex,
    output logic             ins_reg_en,
    output logic             reg_wen,
    output logic [1:0]       PC_CS,
    output logic             PC_EN,
    output logic             PC_mode,
    output logic             ALU_mode,
    output logic [1:0]       ALU_CS1,
    output logic [1:0]       ALU_CS2,
    output logic [2:0]       BUS_ADDR_CS,
    output logic [2:0]       BUS_DATA_CS,
    output logic             BUS_mode,
    output logic             BUS_start_transaction,
    output logic             instr_retired,
    output logic [RET_W-1:0] retire_cnt,
    output logic             bus_err,
    output logic             halted
);
    localparam logic [1:0] PC_CS_INC        = 2'd0;
    localparam logic [1:0] PC_CS_ALU        = 2'd1;
    localparam logic       PC_MODE_INC      = 1'b0;
    localparam logic       PC_MODE_JAL      = 1'b1;
    localparam logic       ALU_MODE_ADD     = 1'b0;
    localparam logic       ALU_MODE_SUB     = 1'b1;
    localparam logic [1:0] ALU_CS1_REG0     = 2'd0;
    localparam logic [1:0] ALU_CS1_IM       = 2'd1;
    localparam logic [1:0] ALU_CS2_REG1     = 2'd1;
    localparam logic [2:0] BUS_ADDR_CS_PC   = 3'd0;
    localparam logic [2:0] BUS_ADDR_CS_ALU  = 3'd1;
    localparam logic [2:0] BUS_DATA_CS_REG0 = 3'd0;
    localparam logic       BUS_MODE_READ    = 1'b0;
    localparam logic       BUS_MODE_WRITE   = 1'b1;

    localparam int TW = $clog2(BUS_TIMEOUT);
    localparam int AW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE, IF_REQ, IF_WAIT, EX_ALU, EX_MREQ, EX_MWAIT, EX_WB, ERR
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tmo_cnt;
    logic [AW-1:0] alu_cnt;

    logic legal, mem_op, use_im, sub_op, wb_op, waiting, alu_last, tmo_last, mem_done;

    assign legal    = $onehot({ins_ADD, ins_SUB, ins_SW, ins_LW, ins_ADDI, ins_LUI, ins_JAL, ins_BEQ});
    assign mem_op   = ins_SW | ins_LW;
    assign use_im   = ins_ADDI | mem_op;
    assign sub_op   = ins_SUB | ins_BEQ;
    assign wb_op    = ins_ADD | ins_SUB | ins_ADDI | ins_LUI | ins_JAL;
    assign waiting  = (state == IF_WAIT) || (state == EX_MWAIT);
    assign alu_last = (alu_cnt == AW'(ALU_LAT - 1));
    // tmo_cnt holds the number of wait cycles already spent, so this is the last allowed one
    assign tmo_last = (tmo_cnt == TW'(BUS_TIMEOUT - 1));
    assign mem_done = ins_SW ? BUS_write_done : BUS_rdata_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            alu_cnt    <= '0;
            retire_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= (waiting && state_nx == state) ? tmo_cnt + 1'b1 : '0;
            alu_cnt <= (state == EX_ALU && state_nx == EX_ALU) ? alu_cnt + 1'b1 : '0;
            if (instr_retired)
                retire_cnt <= retire_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx              = state;
        Mif                   = 1'b0;
        Mex                   = 1'b0;
        ins_reg_en            = 1'b0;
        reg_wen               = 1'b0;
        PC_CS                 = PC_CS_INC;
        PC_EN                 = 1'b0;
        PC_mode               = PC_MODE_INC;
        ALU_mode              = ALU_MODE_ADD;
        ALU_CS1               = ALU_CS1_REG0;
        ALU_CS2               = ALU_CS2_REG1;
        BUS_ADDR_CS           = BUS_ADDR_CS_PC;
        BUS_DATA_CS           = BUS_DATA_CS_REG0;
        BUS_mode              = BUS_MODE_READ;
        BUS_start_transaction = 1'b0;
        instr_retired         = 1'b0;
        bus_err               = 1'b0;
        halted                = 1'b0;

        if (state inside {EX_ALU, EX_MREQ, EX_MWAIT, EX_WB}) begin
            Mex      = 1'b1;
            ALU_CS1  = use_im ? ALU_CS1_IM : ALU_CS1_REG0;
            ALU_mode = sub_op ? ALU_MODE_SUB : ALU_MODE_ADD;
        end
        // address and direction stay up for the whole data transfer
        if (state == EX_MREQ || state == EX_MWAIT) begin
            BUS_ADDR_CS = BUS_ADDR_CS_ALU;
            BUS_mode    = ins_SW ? BUS_MODE_WRITE : BUS_MODE_READ;
        end

        case (state)
            IDLE: if (run) state_nx = IF_REQ;
            IF_REQ: begin
                Mif                   = 1'b1;
                BUS_start_transaction = 1'b1;
                PC_EN                 = 1'b1;
                state_nx              = IF_WAIT;
            end
            IF_WAIT: begin
                Mif = 1'b1;
                if (BUS_rdata_valid) begin
                    ins_reg_en = 1'b1;
                    state_nx   = EX_ALU;
                end else if (tmo_last) begin
                    state_nx = ERR;
                end
            end
            EX_ALU: begin
                if (!legal) begin
                    state_nx = ERR;
                end else if (alu_last) begin
                    if (mem_op) begin
                        state_nx = EX_MREQ;
                    end else begin
                        reg_wen       = wb_op;
                        instr_retired = 1'b1;
                        if (ins_JAL) begin
                            PC_EN   = 1'b1;
                            PC_CS   = PC_CS_ALU;
                            PC_mode = PC_MODE_JAL;
                        end
                        if (ins_BEQ) begin
                            PC_EN = alu_zero;
                            PC_CS = PC_CS_ALU;
                        end
                    end
                end
            end
            EX_MREQ: begin
                BUS_start_transaction = 1'b1;
                state_nx              = EX_MWAIT;
            end
            EX_MWAIT: begin
                if (mem_done) begin
                    if (ins_SW) instr_retired = 1'b1;
                    else        state_nx      = EX_WB;
                end else if (tmo_last) begin
                    state_nx = ERR;
                end
            end
            EX_WB: begin
                reg_wen       = 1'b1;
                instr_retired = 1'b1;
            end
            ERR: begin
                bus_err = 1'b1;
                halted  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        if (instr_retired)
            state_nx = run ? IF_REQ : IDLE;
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench: a trace model builds per-cycle stimulus and expected outputs from the
// instruction-level rules; each test plays its trace and compares every cycle.
module tb_multicycle_ctrl_fsm;
    localparam int TMO = 16;
    localparam int LAT = 1;
    localparam int RW  = 4;

    localparam logic [1:0] PC_CS_ALU = 2'd1;
    localparam logic [1:0] CS1_IM    = 2'd1;
    localparam logic [1:0] CS2_REG1  = 2'd1;
    localparam logic [2:0] ADDR_ALU  = 3'd1;
    localparam int K_ADD = 0, K_SUB = 1, K_SW = 2, K_LW = 3, K_ADDI = 4, K_LUI = 5, K_JAL = 6, K_BEQ = 7;

    typedef struct packed {
        logic       mif, mex, irl, rwen;
        logic [1:0] pc_cs;
        logic       pc_en, pc_mode, alu_mode;
        logic [1:0] cs1, cs2;
        logic [2:0] acs, dcs;
        logic       bmode, bstart, ret, berr, halt;
    } obs_t;

    typedef struct packed {
        logic       c_run, c_rv, c_wd, c_zero;
        logic [7:0] c_ins;
        obs_t       exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst, run, rv, wd, zero;
    logic [7:0] ins_v;
    logic Mif, Mex, ins_reg_en, reg_wen, PC_EN, PC_mode, ALU_mode, BUS_mode;
    logic BUS_start_transaction, instr_retired, bus_err, halted;
    logic [1:0] PC_CS, ALU_CS1, ALU_CS2;
    logic [2:0] BUS_ADDR_CS, BUS_DATA_CS;
    logic [RW-1:0] retire_cnt;
    obs_t obs;

    cyc_t tr[$];
    int n_chk = 0, n_pass = 0, exp_ret = 0;

    multicycle_ctrl_fsm #(.BUS_TIMEOUT(TMO), .ALU_LAT(LAT), .RET_W(RW)) dut (
        .clk(clk), .rst(rst), .run(run), .BUS_rdata_valid(rv), .BUS_write_done(wd),
        .ins_ADD(ins_v[K_ADD]), .ins_SUB(ins_v[K_SUB]), .ins_SW(ins_v[K_SW]), .ins_LW(ins_v[K_LW]),
        .ins_ADDI(ins_v[K_ADDI]), .ins_LUI(ins_v[K_LUI]), .ins_JAL(ins_v[K_JAL]), .ins_BEQ(ins_v[K_BEQ]),
        .alu_zero(zero), .Mif(Mif), .Mex(Mex), .ins_reg_en(ins_reg_en), .reg_wen(reg_wen),
        .PC_CS(PC_CS), .PC_EN(PC_EN), .PC_mode(PC_mode), .ALU_mode(ALU_mode),
        .ALU_CS1(ALU_CS1), .ALU_CS2(ALU_CS2), .BUS_ADDR_CS(BUS_ADDR_CS), .BUS_DATA_CS(BUS_DATA_CS),
        .BUS_mode(BUS_mode), .BUS_start_transaction(BUS_start_transaction),
        .instr_retired(instr_retired), .retire_cnt(retire_cnt), .bus_err(bus_err), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs = {Mif, Mex, ins_reg_en, reg_wen, PC_CS, PC_EN, PC_mode, ALU_mode, ALU_CS1, ALU_CS2,
                  BUS_ADDR_CS, BUS_DATA_CS, BUS_mode, BUS_start_transaction, instr_retired, bus_err, halted};

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic obs_t base();
        obs_t o = '0;
        o.cs2 = CS2_REG1;
        return o;
    endfunction

    function automatic void push(logic r, logic v, logic d, logic z, logic [7:0] i, obs_t e);
        cyc_t c;
        c = '{c_run: r, c_rv: v, c_wd: d, c_zero: z, c_ins: i, exp: e};
        tr.push_back(c);
    endfunction

    function automatic void gen_idle(int n, logic r);
        for (int k = 0; k < n; k++) push(r, rnd(), rnd(), rnd(), 8'($urandom), base());
    endfunction

    function automatic void gen_err(int n);
        obs_t e = base();
        e.berr = 1'b1;
        e.halt = 1'b1;
        for (int k = 0; k < n; k++) push(1'b1, rnd(), rnd(), rnd(), 8'($urandom), e);
    endfunction

    // request cycle plus fwait wait cycles; data arrives on the last one when answered=1
    function automatic void gen_fetch(int fwait, logic answered);
        obs_t e = base();
        e.mif = 1'b1; e.bstart = 1'b1; e.pc_en = 1'b1;
        push(rnd(), rnd(), rnd(), rnd(), 8'($urandom), e);
        for (int c = 1; c <= fwait; c++) begin
            e = base();
            e.mif = 1'b1;
            e.irl = answered && (c == fwait);
            push(rnd(), e.irl, rnd(), rnd(), 8'($urandom), e);
        end
    endfunction

    // mwait = 0 models a data transfer that is never answered
    function automatic void gen_exec(logic [7:0] i, logic z, logic ra, int mwait);
        obs_t e;
        logic mem = i[K_SW] | i[K_LW];
        logic ok  = $onehot(i);
        int   n   = (mwait == 0) ? TMO : mwait;
        for (int k = 0; k < LAT; k++) begin
            e = base();
            e.mex = 1'b1;
            e.cs1 = (i[K_ADDI] | mem) ? CS1_IM : 2'd0;
            e.alu_mode = i[K_SUB] | i[K_BEQ];
            if (k == LAT - 1 && ok && !mem) begin
                e.rwen = !i[K_BEQ];
                if (i[K_JAL]) begin e.pc_en = 1'b1; e.pc_cs = PC_CS_ALU; e.pc_mode = 1'b1; end
                if (i[K_BEQ]) begin e.pc_en = z; e.pc_cs = PC_CS_ALU; end
                e.ret = 1'b1;
                exp_ret++;
            end
            push(ra, rnd(), rnd(), i[K_BEQ] ? z : rnd(), i, e);
        end
        if (!ok || !mem) return;
        e = base();
        e.mex = 1'b1; e.cs1 = CS1_IM; e.bstart = 1'b1; e.acs = ADDR_ALU; e.bmode = i[K_SW];
        push(ra, rnd(), rnd(), rnd(), i, e);
        for (int c = 1; c <= n; c++) begin
            logic done = (mwait != 0) && (c == mwait);
            e = base();
            e.mex = 1'b1; e.cs1 = CS1_IM; e.acs = ADDR_ALU; e.bmode = i[K_SW];
            if (done && i[K_SW]) begin e.ret = 1'b1; exp_ret++; end
            push(ra, i[K_LW] ? done : rnd(), i[K_SW] ? done : rnd(), rnd(), i, e);
        end
        if (mwait != 0 && i[K_LW]) begin
            e = base();
            e.mex = 1'b1; e.cs1 = CS1_IM; e.rwen = 1'b1; e.ret = 1'b1;
            exp_ret++;
            push(ra, rnd(), rnd(), rnd(), i, e);
        end
    endfunction

    task automatic drive(input cyc_t c);
        run = c.c_run; rv = c.c_rv; wd = c.c_wd; zero = c.c_zero; ins_v = c.c_ins;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; rv = 1'b0; wd = 1'b0; zero = 1'b0; ins_v = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; rv = 1'b1; wd = 1'b1; zero = 1'b0; ins_v = 8'h01;
        @(negedge clk);
        n_chk++;
        if (obs !== base()) $display("FAIL reset_outputs: got %h want %h", obs, base()); else n_pass++;
        n_chk++;
        if (retire_cnt !== '0) $display("FAIL reset_retire_cnt: got %0d want 0", retire_cnt); else n_pass++;
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_add();
        do_reset();
        gen_idle(1, 1'b1);
        gen_fetch(2, 1'b1);
        gen_exec(8'h01 << K_ADD, 1'b0, 1'b0, 1);
        gen_idle(2, 1'b0);
        foreach (tr[i]) begin
            drive(tr[i]);
            n_chk++;
            if (obs !== tr[i].exp) $display("FAIL add cyc%0d: got %h want %h", i, obs, tr[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        tr.delete();
        n_chk++;
        if (retire_cnt !== 4'd1) $display("FAIL add_retire_cnt: got %0d want 1", retire_cnt); else n_pass++;
    endtask

    task automatic test_lw_beq();
        do_reset();
        gen_idle(1, 1'b1);
        gen_fetch($urandom_range(1, 4), 1'b1);
        gen_exec(8'h01 << K_LW, 1'b0, 1'b1, $urandom_range(1, 5));
        gen_fetch(1, 1'b1);
        gen_exec(8'h01 << K_BEQ, 1'b1, 1'b1, 1);
        gen_fetch(3, 1'b1);
        gen_exec(8'h01 << K_BEQ, 1'b0, 1'b0, 1);
        gen_idle(1, 1'b0);
        foreach (tr[i]) begin
            drive(tr[i]);
            n_chk++;
            if (obs !== tr[i].exp) $display("FAIL lw_beq cyc%0d: got %h want %h", i, obs, tr[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        tr.delete();
        n_chk++;
        if (retire_cnt !== 4'd3) $display("FAIL lw_beq_retire_cnt: got %0d want 3", retire_cnt); else n_pass++;
    endtask

    task automatic test_run_drop_sw();
        do_reset();
        gen_idle(1, 1'b1);
        gen_fetch(1, 1'b1);
        gen_exec(8'h01 << K_SW, 1'b0, 1'b0, 4);
        gen_idle(3, 1'b0);
        foreach (tr[i]) begin
            drive(tr[i]);
            n_chk++;
            if (obs !== tr[i].exp) $display("FAIL run_drop_sw cyc%0d: got %h want %h", i, obs, tr[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        tr.delete();
        n_chk++;
        if (retire_cnt !== 4'd1) $display("FAIL run_drop_sw_cnt: got %0d want 1", retire_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ra = 1'b0;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            logic [7:0] i = 8'h01 << $urandom_range(0, 7);
            if (!ra) begin
                gen_idle($urandom_range(0, 2), 1'b0);
                gen_idle(1, 1'b1);
            end
            ra = ($urandom_range(0, 3) != 0);
            gen_fetch($urandom_range(1, 5), 1'b1);
            gen_exec(i, rnd(), ra, $urandom_range(1, 5));
            foreach (tr[k]) begin
                drive(tr[k]);
                n_chk++;
                if (obs !== tr[k].exp) $display("FAIL b2b ins%0d cyc%0d: got %h want %h", n, k, obs, tr[k].exp);
                else n_pass++;
                @(posedge clk); #1;
            end
            tr.delete();
            n_chk++;
            if (retire_cnt !== RW'(exp_ret))
                $display("FAIL b2b_retire_cnt ins%0d: got %0d want %0d", n, retire_cnt, RW'(exp_ret));
            else n_pass++;
        end
    endtask

    task automatic test_timeouts();
        do_reset();
        gen_idle(1, 1'b1);
        gen_fetch(TMO, 1'b1);
        gen_exec(8'h01 << K_ADDI, 1'b0, 1'b1, 1);
        gen_fetch(1, 1'b1);
        gen_exec(8'h01 << K_LW, 1'b0, 1'b0, TMO);
        gen_idle(1, 1'b0);
        gen_idle(1, 1'b1);
        gen_fetch(TMO, 1'b0);
        gen_err(5);
        foreach (tr[i]) begin
            drive(tr[i]);
            n_chk++;
            if (obs !== tr[i].exp) $display("FAIL fetch_timeout cyc%0d: got %h want %h", i, obs, tr[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        tr.delete();
        n_chk++;
        if (retire_cnt !== 4'd2) $display("FAIL timeout_edge_cnt: got %0d want 2", retire_cnt); else n_pass++;
        do_reset();
        gen_idle(1, 1'b1);
        gen_fetch(1, 1'b1);
        gen_exec(8'h01 << K_SW, 1'b0, 1'b1, 0);
        gen_err(3);
        foreach (tr[i]) begin
            drive(tr[i]);
            n_chk++;
            if (obs !== tr[i].exp) $display("FAIL mem_timeout cyc%0d: got %h want %h", i, obs, tr[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        tr.delete();
    endtask

    task automatic test_illegal();
        logic [7:0] bad [2];
        bad[0] = (8'h01 << K_ADD) | (8'h01 << K_SUB);
        bad[1] = 8'h00;
        for (int b = 0; b < 2; b++) begin
            do_reset();
            gen_idle(1, 1'b1);
            gen_fetch(2, 1'b1);
            gen_exec(bad[b], 1'b0, 1'b1, 1);
            gen_err(3);
            foreach (tr[i]) begin
                drive(tr[i]);
                n_chk++;
                if (obs !== tr[i].exp) $display("FAIL illegal%0d cyc%0d: got %h want %h", b, i, obs, tr[i].exp);
                else n_pass++;
                @(posedge clk); #1;
            end
            tr.delete();
            n_chk++;
            if (retire_cnt !== 4'd0) $display("FAIL illegal%0d_cnt: got %0d want 0", b, retire_cnt); else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        gen_idle(1, 1'b1);
        gen_fetch(3, 1'b0);
        foreach (tr[i]) begin
            drive(tr[i]);
            n_chk++;
            if (obs !== tr[i].exp) $display("FAIL rst_mid cyc%0d: got %h want %h", i, obs, tr[i].exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        tr.delete();
        rst = 1'b1; run = 1'b0; rv = 1'b0;
        #1;
        n_chk++;
        if (obs !== base()) $display("FAIL rst_mid_async: got %h want %h", obs, base()); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; rv = 1'b1; ins_v = 8'h01;
        @(negedge clk);
        n_chk++;
        if (obs !== base()) $display("FAIL rst_mid_stale_valid: got %h want %h", obs, base()); else n_pass++;
        @(posedge clk); #1;
        rv = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== base() || retire_cnt !== 4'd0)
            $display("FAIL rst_mid_idle: got %h cnt %0d want %h cnt 0", obs, retire_cnt, base());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; rv = 1'b0; wd = 1'b0; zero = 1'b0; ins_v = '0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_lw_beq();
        test_run_drop_sw();
        test_back_to_back();
        test_timeouts();
        test_illegal();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
